cp0_intc: RTL and testbench
===========================

# cp0_intc

Parametrised coprocessor-0 interrupt controller for the five-stage pipeline. It sits beside the M stage and owns SR, Cause, EPC and PRId. It takes a configurable number of hardware interrupt lines, each selectable as level or edge mode. It raises a single interrupt request to flush the pipeline and redirect fetch, and it returns the saved EPC on eret.

## Interface
Parameters:
- NINT, 6: number of hardware interrupt lines; legal range 1..16.
- EDGE_MASK, 0: NINT-bit mask; bit i=1 makes line i edge-triggered (sticky), 0 makes it level.
- PRID_VALUE, 32'h0000_2016: constant returned for PRId.

Ports (one clock; reset is synchronous and active-high):
- clk, input, 1: rising-edge clock.
- reset, input, 1: synchronous active-high reset.
- hw_int, input, NINT: device interrupt lines, asynchronous to nothing (same clk domain).
- we, input, 1: mtc0 write strobe from M stage.
- sel, input, 5: CP0 register number: 12 SR, 13 Cause, 14 EPC, 15 PRId.
- wdata, input, 32: mtc0 data (already forwarded).
- rdata, output, 32: mfc0 read data, combinational on sel.
- pc_m, input, 32: PC of the instruction currently in M.
- eret, input, 1: eret executing (one-cycle pulse).
- int_req, output, 1: interrupt taken this cycle; flush/redirect.
- epc, output, 32: current EPC register.
- exl, output, 1: SR.EXL.
- int_id, output, 4: index of the line that caused the last accepted interrupt.

## Operation
- SR layout: IM = bits [10+NINT-1:10], EXL = bit 1, IE = bit 0, all other bits read 0.
- Cause layout: IP = bits [10+NINT-1:10], ExcCode = bits [6:2] (always 0 for interrupt), all other bits 0.
- IP update each cycle:
  - Level line: IP[i] <= hw_int[i].
  - Edge line: IP[i] <= 1 on rise (hw_int[i] & ~prev[i]). It holds until software writes 0 to that bit via mtc0 Cause. A rise in the same cycle as the clearing write wins (stays 1).
  - prev <= hw_int every cycle.
- mtc0 Cause modifies only edge-mode IP bits. Level bits and ExcCode are read-only.
- int_req = IE & ~EXL & |(IP & IM). It is combinational from registered state only (no hw_int path).
- Accept (int_req=1 at clock edge):
  - EXL <= 1.
  - EPC <= {pc_m[31:2],2'b00}.
  - int_id <= lowest index i with IP[i]&IM[i] (lowest index = highest priority).
- eret: EXL <= 0.
- mtc0 writes:
  - SR: writes IM, EXL, IE.
  - EPC: writes wdata with bits [1:0] forced 0.
  - PRId: writes ignored.
  - Unknown sel: writes ignored; reads return 0.
- Precedence within one cycle: reset > accept > eret > mtc0.
  - Accept drops a coincident mtc0 entirely; the M instruction is flushed and re-executed from EPC.
  - eret plus mtc0 SR: eret controls EXL; IM/IE take wdata.
- eret with EXL already 0: EXL stays 0, no other effect.

## Timing
- Reset values: SR=0 (IE=0, EXL=0, IM=0), IP=0, prev=0, EPC=0, int_id=0. Consequently int_req=0, exl=0, epc=0, rdata=0 for sel 12/13/14.
- hw_int to IP: 1 cycle. IP to int_req: 0 cycles. So an enabled line asserted before edge n gives int_req=1 during cycle n+1.
- int_req is high for exactly one cycle per acceptance, because EXL sets at that edge.
- eret at edge n: EXL=0 from cycle n+1. A still-pending enabled line re-raises int_req in cycle n+1.
- rdata reflects register state after the most recent edge. There is no write-through of wdata in the same cycle.
- A reset asserted mid-handler (EXL=1) clears everything at that edge. Edge latches are lost.

## Test plan
- Reset then idle: hold reset 2 cycles, hw_int=6'h3F, IM=0. Require int_req=0, epc=0, rdata(sel 12)=0.
- Level interrupt: mtc0 SR=32'h0000_0401 (IM0, IE), pulse hw_int[0] high, pc_m=32'h0000_3014. Require int_req=1 for one cycle, EPC=32'h0000_3014, exl=1, int_id=0. Then eret gives exl=0; with hw_int[0] still high, int_req=1 again the next cycle.
- Edge sticky (EDGE_MASK=6'b000100): 1-cycle pulse on hw_int[2] with IE=0. Require Cause bit 12 stays 1 for 10 cycles. mtc0 Cause=0 clears it. Setting SR=32'h0000_1001 after clear gives no int_req.
- Priority: hw_int=6'b101000, IM all set, IE=1. Require int_id=3.
- Collisions: int_req with we=1, sel=14, wdata=32'hDEAD_BEEF in the same cycle. Require EPC=pc_m (write dropped). Separately, eret with mtc0 SR wdata=32'h0000_0403 gives exl=0, IE=1, IM0=1.
- Width/alignment: mtc0 EPC=32'h0000_3007 reads back 32'h0000_3004. sel=15 reads PRID_VALUE. sel=9 reads 0.

Source files
------------

// File: rtl/cp0_intc.sv
// Coprocessor-0 interrupt controller: owns SR, Cause, EPC and PRId, latches
// hardware interrupt lines (level or sticky edge per line), raises a single
// flush/redirect request and saves the interrupted PC for eret.
module cp0_intc #(
  parameter int                NINT       = 6,
  parameter logic [NINT-1:0]   EDGE_MASK  = '0,
  parameter logic [31:0]       PRID_VALUE = 32'h0000_2016
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NINT-1:0] hw_int,
  input  logic            we,
  input  logic [4:0]      sel,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  input  logic [31:0]     pc_m,
  input  logic            eret,
  output logic            int_req,
  output logic [31:0]     epc,
  output logic            exl,
  output logic [3:0]      int_id
);

  localparam logic [4:0] SEL_SR    = 5'd12;
  localparam logic [4:0] SEL_CAUSE = 5'd13;
  localparam logic [4:0] SEL_EPC   = 5'd14;
  localparam logic [4:0] SEL_PRID  = 5'd15;
  localparam int         IP_LSB    = 10;

  // Architectural state
  logic [NINT-1:0] im_q;
  logic            ie_q;
  logic            exl_q;
  logic [NINT-1:0] ip_q;
  logic [NINT-1:0] prev_q;
  logic [31:0]     epc_q;
  logic [3:0]      int_id_q;

  // Derived combinational signals
  logic [NINT-1:0] pending;
  logic [3:0]      pend_id;
  logic [NINT-1:0] ip_next;
  logic            wr_sr;
  logic            wr_cause;
  logic            wr_epc;
  logic [31:0]     sr_word;
  logic [31:0]     cause_word;

  // Only registered state feeds the request, so hw_int never reaches
  // int_req without passing through the IP flops.
  assign pending = ip_q & im_q;
  assign int_req = ie_q & ~exl_q & (|pending);

  // An accepted interrupt flushes the M instruction, so its mtc0 is dropped.
  assign wr_sr    = we & ~int_req & (sel == SEL_SR);
  assign wr_cause = we & ~int_req & (sel == SEL_CAUSE);
  assign wr_epc   = we & ~int_req & (sel == SEL_EPC);

  // Priority encoder: lowest pending index wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    pend_id = '0;
    for (int i = NINT - 1; i >= 0; i--) begin
      if (pending[i]) pend_id = 4'(i);
    end
  end

  // Next IP: level lines follow the pin; edge lines latch a rise and only
  // clear through a Cause write, with a coincident rise taking precedence.
  always_comb begin
    ip_next = '0;
    for (int i = 0; i < NINT; i++) begin
      if (EDGE_MASK[i]) begin
        ip_next[i] = (hw_int[i] & ~prev_q[i]) |
                     (wr_cause ? wdata[IP_LSB + i] : ip_q[i]);
      end else begin
        ip_next[i] = hw_int[i];
      end
    end
  end

  // Register views and mfc0 read mux (reflects state after the last edge).
  always_comb begin
    sr_word                   = '0;
    sr_word[IP_LSB +: NINT]   = im_q;
    sr_word[1]                = exl_q;
    sr_word[0]                = ie_q;
    cause_word                = '0;
    cause_word[IP_LSB +: NINT] = ip_q;
    case (sel)
      SEL_SR:    rdata = sr_word;
      SEL_CAUSE: rdata = cause_word;
      SEL_EPC:   rdata = epc_q;
      SEL_PRID:  rdata = PRID_VALUE;
      default:   rdata = '0;
    endcase
  end

  // State update with precedence reset > accept > eret > mtc0.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      im_q     <= '0;
      ie_q     <= 1'b0;
      exl_q    <= 1'b0;
      ip_q     <= '0;
      prev_q   <= '0;
      epc_q    <= '0;
      int_id_q <= '0;
    end else begin
      prev_q <= hw_int;
      ip_q   <= ip_next;
      if (int_req) begin
        exl_q    <= 1'b1;
        epc_q    <= {pc_m[31:2], 2'b00};
        int_id_q <= pend_id;
      end else begin
        if (wr_sr) begin
          im_q <= wdata[IP_LSB +: NINT];
          ie_q <= wdata[0];
        end
        if (eret) begin
          exl_q <= 1'b0;
        end else if (wr_sr) begin
          exl_q <= wdata[1];
        end
        if (wr_epc) begin
          epc_q <= {wdata[31:2], 2'b00};
        end
      end
    end
  end

  assign epc    = epc_q;
  assign exl    = exl_q;
  assign int_id = int_id_q;

  // Bits that are architecturally ignored (alignment bits, unused wdata).
  logic unused_bits;
  assign unused_bits = ^{pc_m[1:0], wdata};

endmodule

// File: tb/tb_cp0_intc.sv
// Directed bench for cp0_intc: stimulus pushes expected interrupt
// acceptances into a scoreboard; a monitor pops and checks them whenever the
// DUT raises int_req. Register reads are checked directly.
module tb_cp0_intc;

  localparam int NINT = 6;

  typedef struct {
    logic [31:0] epc;
    logic [3:0]  id;
  } accept_t;

  logic            clk = 1'b0;
  logic            reset;
  logic [NINT-1:0] hw_int;
  logic            we;
  logic [4:0]      sel;
  logic [31:0]     wdata;
  logic [31:0]     rdata;
  logic [31:0]     pc_m;
  logic            eret;
  logic            int_req;
  logic [31:0]     epc;
  logic            exl;
  logic [3:0]      int_id;

  int errors = 0;
  int checks = 0;
  accept_t sb[$];

  cp0_intc #(
    .NINT      (NINT),
    .EDGE_MASK (6'b000100),
    .PRID_VALUE(32'h0000_2016)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .hw_int (hw_int),
    .we     (we),
    .sel    (sel),
    .wdata  (wdata),
    .rdata  (rdata),
    .pc_m   (pc_m),
    .eret   (eret),
    .int_req(int_req),
    .epc    (epc),
    .exl    (exl),
    .int_id (int_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mtc0(input logic [4:0] s, input logic [31:0] d);
    sel   = s;
    wdata = d;
    we    = 1'b1;
    tick();
    we    = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [4:0] s, input logic [31:0] exp);
    sel = s;
    #1;
    check(name, rdata, exp);
  endtask

  task automatic expect_accept(input logic [31:0] e_epc, input logic [3:0] e_id);
    accept_t a;
    a.epc = e_epc;
    a.id  = e_id;
    sb.push_back(a);
  endtask

  // Monitor: each cycle int_req is high, pop the expected acceptance and
  // check the saved state just after the accepting edge.
  always @(negedge clk) begin
    if (reset === 1'b0 && int_req === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_int_req", 32'(int_req), 32'd0);
      end else begin
        accept_t a;
        a = sb.pop_front();
        @(posedge clk);
        #1;
        check("accept_epc", epc, a.epc);
        check("accept_int_id", 32'(int_id), 32'(a.id));
        check("accept_exl", 32'(exl), 32'd1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; hw_int = 6'h3F; we = 1'b0; sel = 5'd12;
    wdata = '0; pc_m = '0; eret = 1'b0;

    // Reset then idle
    tick(); tick();
    reset = 1'b0;
    check("rst_int_req", 32'(int_req), 32'd0);
    check("rst_exl", 32'(exl), 32'd0);
    check("rst_epc", epc, 32'd0);
    read_check("rst_sr", 5'd12, 32'd0);
    read_check("rst_cause", 5'd13, 32'd0);
    read_check("rst_epc_rd", 5'd14, 32'd0);
    tick();
    read_check("idle_cause_ip", 5'd13, 32'h0000_FC00);
    check("idle_no_req", 32'(int_req), 32'd0);
    hw_int = '0;
    mtc0(5'd13, 32'd0);
    read_check("idle_cause_clr", 5'd13, 32'd0);

    // Level interrupt, eret re-raise while the line stays high
    mtc0(5'd12, 32'h0000_0401);
    read_check("sr_readback", 5'd12, 32'h0000_0401);
    pc_m = 32'h0000_3014;
    hw_int = 6'b000001;
    expect_accept(32'h0000_3014, 4'd0);
    tick();
    check("lvl_req_high", 32'(int_req), 32'd1);
    tick();
    check("lvl_exl_set", 32'(exl), 32'd1);
    check("lvl_req_one_cycle", 32'(int_req), 32'd0);
    pc_m = 32'h0000_3018;
    eret = 1'b1;
    expect_accept(32'h0000_3018, 4'd0);
    tick();
    eret = 1'b0;
    check("eret_exl_clr", 32'(exl), 32'd0);
    check("eret_reraise", 32'(int_req), 32'd1);
    tick();
    hw_int = '0;
    eret = 1'b1;
    tick();
    eret = 1'b0;
    check("lvl_done_exl", 32'(exl), 32'd0);
    check("lvl_done_req", 32'(int_req), 32'd0);

    // Edge sticky on line 2 with IE=0
    mtc0(5'd12, 32'd0);
    hw_int = 6'b000100;
    tick();
    hw_int = '0;
    for (int i = 0; i < 10; i++) begin
      read_check("edge_sticky", 5'd13, 32'h0000_1000);
      tick();
    end
    mtc0(5'd13, 32'd0);
    read_check("edge_cleared", 5'd13, 32'd0);
    mtc0(5'd12, 32'h0000_1001);
    check("edge_no_req_a", 32'(int_req), 32'd0);
    tick();
    check("edge_no_req_b", 32'(int_req), 32'd0);
    mtc0(5'd12, 32'd0);
    hw_int = 6'b000100;
    mtc0(5'd13, 32'd0);
    hw_int = '0;
    read_check("edge_rise_wins", 5'd13, 32'h0000_1000);
    mtc0(5'd13, 32'd0);
    read_check("edge_cleared2", 5'd13, 32'd0);

    // Priority: lines 3 and 5 pending, line 3 wins
    hw_int = 6'b101000;
    pc_m = 32'h0000_4000;
    expect_accept(32'h0000_4000, 4'd3);
    mtc0(5'd12, 32'h0000_FC01);
    tick();
    hw_int = '0;
    eret = 1'b1;
    tick();
    eret = 1'b0;
    check("prio_done_req", 32'(int_req), 32'd0);

    // Accept drops a coincident mtc0 EPC
    pc_m = 32'h0000_5000;
    hw_int = 6'b000001;
    expect_accept(32'h0000_5000, 4'd0);
    tick();
    sel = 5'd14; wdata = 32'hDEAD_BEEF; we = 1'b1;
    tick();
    we = 1'b0;
    hw_int = '0;
    read_check("collide_epc", 5'd14, 32'h0000_5000);
    check("collide_exl", 32'(exl), 32'd1);

    // eret plus mtc0 SR: eret owns EXL, IM/IE take wdata
    eret = 1'b1;
    mtc0(5'd12, 32'h0000_0403);
    eret = 1'b0;
    check("eret_sr_exl", 32'(exl), 32'd0);
    read_check("eret_sr_val", 5'd12, 32'h0000_0401);
    check("eret_sr_no_req", 32'(int_req), 32'd0);

    // Width / alignment / read-only registers
    mtc0(5'd14, 32'h0000_3007);
    read_check("epc_align", 5'd14, 32'h0000_3004);
    read_check("prid", 5'd15, 32'h0000_2016);
    read_check("unknown_sel", 5'd9, 32'd0);
    mtc0(5'd15, 32'h1234_5678);
    read_check("prid_ro", 5'd15, 32'h0000_2016);

    // Reset mid-handler clears everything
    pc_m = 32'h0000_6000;
    hw_int = 6'b000001;
    expect_accept(32'h0000_6000, 4'd0);
    tick();
    tick();
    check("mid_exl_set", 32'(exl), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    hw_int = '0;
    check("mid_rst_exl", 32'(exl), 32'd0);
    check("mid_rst_epc", epc, 32'd0);
    read_check("mid_rst_sr", 5'd12, 32'd0);
    check("mid_rst_req", 32'(int_req), 32'd0);

    tick(); tick();
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
